// File: rtl/pc_fetch_if.sv
// ============================================================================
// Module : pc_fetch_if
// Brief  : Instruction-memory fetch handshake (req/addr out, ack/rdata back).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface pc_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  // Fetch unit side
  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  // Instruction memory side
  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

`default_nettype wire

// File: rtl/pc_fetch.sv
// ============================================================================
// Module : pc_fetch
// Brief  : Program counter and instruction fetch unit; one fetch in flight,
//          instruction held for decode until retired.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  wire logic        i_clk,
  input  wire logic        i_rst_n,
  input  wire logic        i_pc_src,
  input  wire logic [29:0] i_pc30,
  input  wire logic        i_stall,
  pc_fetch_if.master       imem,
  output logic [31:0]      o_instr,
  output logic             o_instr_valid,
  output logic [31:0]      o_pc,
  output logic [29:0]      o_incr_pc,
  output logic [31:0]      o_retired_cnt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  localparam logic [29:0] c_RESET_PC30 = RESET_PC[31:2];

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic [29:0] r_pc;
  logic [29:0] w_pc_inc;
  logic [29:0] w_pc_nxt;
  logic [31:0] r_instr;
  logic        r_valid;
  logic [31:0] r_retired_cnt;
  logic        w_fetch_done;
  logic        w_retire;

  assign w_pc_inc     = r_pc + 30'd1;
  assign w_fetch_done = (r_state == S_REQ)  && imem.imem_ack;
  assign w_retire     = (r_state == S_HOLD) && !i_stall;
  // Redirect inputs only matter at the retire cycle
  assign w_pc_nxt     = i_pc_src ? i_pc30 : w_pc_inc;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  w_state_nxt = S_REQ;
      S_REQ:   if (imem.imem_ack) w_state_nxt = S_HOLD;
      S_HOLD:  if (!i_stall)      w_state_nxt = S_REQ;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc          <= c_RESET_PC30;
      r_retired_cnt <= 32'd0;
    end else if (w_retire) begin
      r_pc          <= w_pc_nxt;
      r_retired_cnt <= r_retired_cnt + 32'd1;
    end
  end

  // o_instr keeps the last fetched word after retire; only valid drops
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_instr <= 32'd0;
      r_valid <= 1'b0;
    end else if (w_fetch_done) begin
      r_instr <= imem.imem_rdata;
      r_valid <= 1'b1;
    end else if (w_retire) begin
      r_valid <= 1'b0;
    end
  end

  assign imem.imem_req  = (r_state == S_REQ);
  assign imem.imem_addr = {r_pc, 2'b00};

  assign o_instr        = r_instr;
  assign o_instr_valid  = r_valid;
  assign o_pc           = {r_pc, 2'b00};
  assign o_incr_pc      = w_pc_inc;
  assign o_retired_cnt  = r_retired_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch.sv
// ============================================================================
// Module : tb_pc_fetch
// Brief  : Directed, table-driven self-checking bench for pc_fetch.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pc_fetch;

  typedef struct {
    logic        stall;
    logic        pc_src;
    logic [29:0] pc30;
    logic        ack;
    logic [31:0] rdata;
    logic        exp_req;
    logic        exp_valid;
    logic [31:0] exp_addr;
    logic [31:0] exp_instr;
    logic [29:0] exp_incr;
    logic [31:0] exp_cnt;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        pc_src;
  logic [29:0] pc30;
  logic        stall;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [29:0] incr_pc;
  logic [31:0] retired_cnt;

  int n_checks;
  int n_errors;

  pc_fetch_if bus ();

  pc_fetch #(.RESET_PC(32'h0040_0000)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_pc_src      (pc_src),
    .i_pc30        (pc30),
    .i_stall       (stall),
    .imem          (bus.master),
    .o_instr       (instr),
    .o_instr_valid (instr_valid),
    .o_pc          (pc),
    .o_incr_pc     (incr_pc),
    .o_retired_cnt (retired_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic st, input logic src, input logic [29:0] p30,
                              input logic ak, input logic [31:0] rd,
                              input logic ereq, input logic evld, input logic [31:0] eaddr,
                              input logic [31:0] einstr, input logic [29:0] eincr,
                              input logic [31:0] ecnt);
    vec_t v;
    v.stall = st; v.pc_src = src; v.pc30 = p30; v.ack = ak; v.rdata = rd;
    v.exp_req = ereq; v.exp_valid = evld; v.exp_addr = eaddr;
    v.exp_instr = einstr; v.exp_incr = eincr; v.exp_cnt = ecnt;
    return v;
  endfunction

  task automatic check_outs(input string tag, input logic ereq, input logic evld,
                            input logic [31:0] eaddr, input logic [31:0] einstr,
                            input logic [29:0] eincr, input logic [31:0] ecnt);
    chk({tag, ".req"},   {31'd0, bus.imem_req}, {31'd0, ereq});
    chk({tag, ".valid"}, {31'd0, instr_valid},  {31'd0, evld});
    chk({tag, ".addr"},  bus.imem_addr, eaddr);
    chk({tag, ".pc"},    pc, eaddr);
    chk({tag, ".instr"}, instr, einstr);
    chk({tag, ".incr"},  {2'b00, incr_pc}, {2'b00, eincr});
    chk({tag, ".cnt"},   retired_cnt, ecnt);
  endtask

  // Inputs are applied for the current cycle, outputs checked mid-cycle, then the edge.
  task automatic apply(input vec_t v, input string tag);
    stall = v.stall; pc_src = v.pc_src; pc30 = v.pc30;
    bus.imem_ack = v.ack; bus.imem_rdata = v.rdata;
    #1;
    check_outs(tag, v.exp_req, v.exp_valid, v.exp_addr, v.exp_instr, v.exp_incr, v.exp_cnt);
    @(posedge clk);
    #1;
  endtask

  vec_t tbl [24];

  initial begin
    n_checks = 0;
    n_errors = 0;

    //            st src pc30          ack rdata          req vld addr           instr          incr          cnt
    tbl[0]  = mk(0, 0, 30'h0,        0, 32'h0,         0, 0, 32'h0040_0000, 32'h0,         30'h0010_0001, 0);
    tbl[1]  = mk(0, 0, 30'h0,        1, 32'hA000_0000, 1, 0, 32'h0040_0000, 32'h0,         30'h0010_0001, 0);
    tbl[2]  = mk(0, 0, 30'h0,        0, 32'h0,         0, 1, 32'h0040_0000, 32'hA000_0000, 30'h0010_0001, 0);
    tbl[3]  = mk(0, 0, 30'h0,        1, 32'hA000_0001, 1, 0, 32'h0040_0004, 32'hA000_0000, 30'h0010_0002, 1);
    tbl[4]  = mk(0, 0, 30'h0,        0, 32'h0,         0, 1, 32'h0040_0004, 32'hA000_0001, 30'h0010_0002, 1);
    tbl[5]  = mk(0, 0, 30'h0,        1, 32'hA000_0002, 1, 0, 32'h0040_0008, 32'hA000_0001, 30'h0010_0003, 2);
    tbl[6]  = mk(0, 0, 30'h0,        0, 32'h0,         0, 1, 32'h0040_0008, 32'hA000_0002, 30'h0010_0003, 2);
    tbl[7]  = mk(0, 0, 30'h0,        0, 32'h0,         1, 0, 32'h0040_000C, 32'hA000_0002, 30'h0010_0004, 3);
    tbl[8]  = mk(0, 0, 30'h0,        0, 32'h0,         1, 0, 32'h0040_000C, 32'hA000_0002, 30'h0010_0004, 3);
    tbl[9]  = mk(0, 0, 30'h0,        0, 32'h0,         1, 0, 32'h0040_000C, 32'hA000_0002, 30'h0010_0004, 3);
    tbl[10] = mk(0, 0, 30'h0,        1, 32'h2008_0005, 1, 0, 32'h0040_000C, 32'hA000_0002, 30'h0010_0004, 3);
    tbl[11] = mk(1, 1, 30'h0001_2345, 1, 32'hFFFF_FFFF, 0, 1, 32'h0040_000C, 32'h2008_0005, 30'h0010_0004, 3);
    tbl[12] = mk(0, 0, 30'h0,        0, 32'h0,         0, 1, 32'h0040_000C, 32'h2008_0005, 30'h0010_0004, 3);
    tbl[13] = mk(0, 0, 30'h0,        1, 32'hA000_0004, 1, 0, 32'h0040_0010, 32'h2008_0005, 30'h0010_0005, 4);
    tbl[14] = mk(0, 1, 30'h0010_0040, 0, 32'h0,        0, 1, 32'h0040_0010, 32'hA000_0004, 30'h0010_0005, 4);
    tbl[15] = mk(0, 0, 30'h0,        1, 32'hA000_0005, 1, 0, 32'h0040_0100, 32'hA000_0004, 30'h0010_0041, 5);
    tbl[16] = mk(0, 1, 30'h0010_0004, 0, 32'h0,        0, 1, 32'h0040_0100, 32'hA000_0005, 30'h0010_0041, 5);
    tbl[17] = mk(0, 0, 30'h0,        1, 32'hA000_0006, 1, 0, 32'h0040_0010, 32'hA000_0005, 30'h0010_0005, 6);
    tbl[18] = mk(0, 0, 30'h0010_0040, 0, 32'h0,        0, 1, 32'h0040_0010, 32'hA000_0006, 30'h0010_0005, 6);
    tbl[19] = mk(0, 0, 30'h0,        1, 32'hA000_0007, 1, 0, 32'h0040_0014, 32'hA000_0006, 30'h0010_0006, 7);
    tbl[20] = mk(0, 1, 30'h3FFF_FFFF, 0, 32'h0,        0, 1, 32'h0040_0014, 32'hA000_0007, 30'h0010_0006, 7);
    tbl[21] = mk(0, 0, 30'h0,        1, 32'hA000_0008, 1, 0, 32'hFFFF_FFFC, 32'hA000_0007, 30'h0000_0000, 8);
    tbl[22] = mk(0, 0, 30'h0,        0, 32'h0,         0, 1, 32'hFFFF_FFFC, 32'hA000_0008, 30'h0000_0000, 8);
    tbl[23] = mk(0, 0, 30'h0,        0, 32'h0,         1, 0, 32'h0000_0000, 32'hA000_0008, 30'h0000_0001, 9);

    rst_n = 1'b0; stall = 1'b0; pc_src = 1'b0; pc30 = '0;
    bus.imem_ack = 1'b0; bus.imem_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check_outs("reset", 1'b0, 1'b0, 32'h0040_0000, 32'h0, 30'h0010_0001, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 24; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Stall in HOLD while redirect inputs toggle
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'hB000_0000;
    @(posedge clk);
    #1;
    bus.imem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      stall = 1'b1; pc_src = i[0]; pc30 = 30'h0ABC_0000 + 30'(i);
      #1;
      check_outs($sformatf("stall%0d", i), 1'b0, 1'b1, 32'h0, 32'hB000_0000, 30'h1, 32'd9);
      @(posedge clk);
      #1;
    end
    stall = 1'b0; pc_src = 1'b0; pc30 = 30'h0ABC_0000;
    @(posedge clk);
    #1;
    check_outs("stall_rel", 1'b1, 1'b0, 32'h0000_0004, 32'hB000_0000, 30'h2, 32'd10);

    // Reset while a request is pending, then a late ack
    rst_n = 1'b0;
    #1;
    check_outs("rst_mid", 1'b0, 1'b0, 32'h0040_0000, 32'h0, 30'h0010_0001, 32'd0);
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check_outs("late_ack", 1'b0, 1'b0, 32'h0040_0000, 32'h0, 30'h0010_0001, 32'd0);
    bus.imem_ack = 1'b0;
    @(posedge clk);
    #1;
    check_outs("post_rst_req", 1'b1, 1'b0, 32'h0040_0000, 32'h0, 30'h0010_0001, 32'd0);
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'hC000_0000;
    @(posedge clk);
    #1;
    bus.imem_ack = 1'b0;
    check_outs("post_rst_hold", 1'b0, 1'b1, 32'h0040_0000, 32'hC000_0000, 30'h0010_0001, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
